spi_reg_bridge: RTL and testbench
=================================

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 Parameter ADDR_W, default 7: register address width.
REQ-002 Parameter DATA_W, default 16: register data width; frame length is 1+ADDR_W+DATA_W bits (24 by default).
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth on sclk, cs_n and mosi.
REQ-004 clk  input  1: single system clock; all logic is on its rising edge.
REQ-005 rst  input  1: synchronous, active-low reset.
REQ-006 spi_sclk  input  1: SPI clock from the external master, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-007 spi_cs_n  input  1: active-low frame select, asynchronous.
REQ-008 spi_mosi  input  1: serial data in, MSB first.
REQ-009 spi_miso  output  1: serial read data, MSB first; driven 0 when not in a read data phase.
REQ-010 reg_wr_en  output  1: one-cycle write strobe to the host register file.
REQ-011 reg_rd_en  output  1: one-cycle read strobe to the host register file.
REQ-012 reg_addr  output  ADDR_W: address for reg_wr_en and reg_rd_en.
REQ-013 reg_wr_data  output  DATA_W: write data, valid with reg_wr_en.
REQ-014 reg_rd_data  input  DATA_W: read data, valid exactly 1 clk after reg_rd_en.
REQ-015 frame_err  output  1: one-cycle pulse when a frame is aborted.

Function
REQ-016 spi_sclk/cs_n/mosi SHALL pass through SYNC_STAGES flops; sclk edges are detected from the synchronized value and its previous sample.
REQ-017 Supported spi_sclk frequency SHALL be at most clk/8.
REQ-018 Frame: bit0 = R/W (1 = read), then ADDR_W address bits, then DATA_W data bits; MOSI is sampled on the synchronized rising sclk edge.
REQ-019 FSM states: IDLE, CMD, DATA, WAIT_CS.
- IDLE -> CMD on cs_n falling.
- CMD -> DATA after the 1+ADDR_W-th rising edge.
- DATA -> WAIT_CS after the final rising edge.
- WAIT_CS -> IDLE on cs_n rising.
REQ-020 The bit counter SHALL clear on entry to CMD, increment per rising edge, and never wrap within a frame.
REQ-021 Write: in the clk after the final data bit is sampled, reg_wr_en=1 for one cycle, with reg_addr and reg_wr_data held stable until the next frame.
REQ-022 Read: in the clk after the last address bit is sampled, reg_rd_en=1 for one cycle; reg_rd_data is captured 1 clk later into the TX shift register.
REQ-023 In a read, spi_miso SHALL present TX[MSB] from capture onward and shift on each synchronized falling sclk edge during DATA.
REQ-024 If cs_n rises in CMD or DATA, the FSM SHALL return to IDLE with no wr strobe and pulse frame_err for 1 cycle. A read strobe already issued is not retracted.
REQ-025 Extra sclk edges in WAIT_CS SHALL be ignored; there is no second strobe.
REQ-026 cs_n falling while not in IDLE SHALL be ignored.
REQ-027 reg_wr_en and reg_rd_en SHALL never be high in the same cycle.

Reset
REQ-028 While rst=0 at a clk edge, the state SHALL be IDLE and all outputs SHALL be 0: spi_miso, reg_wr_en, reg_rd_en, reg_addr, reg_wr_data and frame_err.
REQ-029 Synchronizer flops SHALL reset cs_n to 1, sclk to 0 and mosi to 0, so deasserting reset produces no spurious edge.
REQ-030 Reset asserted mid-frame SHALL discard the frame without a strobe; the next frame requires a fresh cs_n falling edge.

Structure
REQ-031 A shared package spi_pkg SHALL hold the state enum (IDLE, CMD, DATA, WAIT_CS), the default ADDR_W/DATA_W constants and the frame-length function.
REQ-032 A sub-module spi_sync_edge SHALL contain the synchronizer and rise/fall detector, instantiated for sclk and cs_n; mosi uses synchronization only.
REQ-033 This block SHALL sit upstream of the host register file and be driven by the SPI test interface.

Verification
REQ-034 Write frame R/W=0, addr 0x12, data 0xBEEF at sclk=clk/10 -> exactly one reg_wr_en with reg_addr=0x12 and reg_wr_data=0xBEEF; frame_err stays 0.
REQ-035 Read frame addr 0x05 with reg_rd_data model 0xA5C3 -> one reg_rd_en with reg_addr=0x05; MISO bits on the 16 data rising edges are 0xA5C3.
REQ-036 cs_n raised after 12 bits of a write frame -> no reg_wr_en, one frame_err pulse; a following write frame of 0x01/0x0001 completes normally.
REQ-037 30 sclk pulses within one cs_n window, write addr 0x7F, data 0xFFFF -> exactly one reg_wr_en; the trailing 6 pulses are ignored.
REQ-038 rst driven low at bit 20 of a write frame -> all outputs 0 next clk, no strobe; a subsequent frame decodes correctly.
REQ-039 Back-to-back frames with a 4-clk cs_n-high gap, write then read of the same address 0x33 -> the read returns the value just written.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register bridge.
// Frame layout: R/W bit, address, data, MSB first.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    WAIT_CS
  } state_t;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 16;

  function automatic int frame_len(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synced level.
// RST_VAL seeds every stage so reset release never fakes an edge.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              w_q;

  assign w_q = r_sync[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= (r_sync << 1) | STAGES'(i_d);
      r_prev <= w_q;
    end
  end

  assign o_rise = w_q & ~r_prev;
  assign o_fall = ~w_q & r_prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 1+ADDR_W+DATA_W bit frames into
// single-cycle register file read/write strobes.
module spi_reg_bridge
  import spi_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              frame_err
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CMD_LEN   = 1 + ADDR_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_LEN - 1);
  localparam logic [CNT_W-1:0] CMD_DONE   = CNT_W'(CMD_LEN);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_mosi;

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES:0]   r_settle;

  state_t            r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr_sh;
  logic [DATA_W-1:0] r_data_sh;
  logic [DATA_W-1:0] r_tx;
  logic              r_rd_pend;
  logic              r_block;

  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_data_nxt;

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (spi_sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (spi_cs_n),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= (r_mosi_sync << 1) | SYNC_STAGES'(spi_mosi);
    end
  end

  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  always_comb begin
    w_addr_nxt = (r_addr_sh << 1) | ADDR_W'(w_mosi);
    w_data_nxt = (r_data_sh << 1) | DATA_W'(w_mosi);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_rw        <= 1'b0;
      r_addr_sh   <= '0;
      r_data_sh   <= '0;
      r_tx        <= '0;
      r_rd_pend   <= 1'b0;
      r_block     <= 1'b0;
      r_settle    <= '0;
      spi_miso    <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      frame_err   <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
      r_rd_pend <= reg_rd_en;
      r_settle  <= {r_settle[SYNC_STAGES-1:0], 1'b1};

      // A cs_n already low at reset release shows up as a fall
      // while the synchronizer settles; ignore it until cs_n rises.
      if (w_cs_fall && !r_settle[SYNC_STAGES]) begin
        r_block <= 1'b1;
      end else if (w_cs_rise) begin
        r_block <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          spi_miso <= 1'b0;
          if (w_cs_fall && r_settle[SYNC_STAGES] && !r_block) begin
            r_state   <= CMD;
            r_bit_cnt <= '0;
          end
        end

        CMD: begin
          if (w_cs_rise) begin
            r_state   <= IDLE;
            frame_err <= 1'b1;
          end else if (w_sclk_rise) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == '0) begin
              r_rw <= w_mosi;
            end else begin
              r_addr_sh <= w_addr_nxt;
            end
            if (r_bit_cnt == CMD_LAST) begin
              r_state <= DATA;
              if (r_rw) begin
                reg_rd_en <= 1'b1;
                reg_addr  <= w_addr_nxt;
              end
            end
          end
        end

        DATA: begin
          if (w_cs_rise) begin
            r_state   <= IDLE;
            frame_err <= 1'b1;
            spi_miso  <= 1'b0;
          end else begin
            if (r_rd_pend && r_rw) begin
              r_tx     <= reg_rd_data;
              spi_miso <= reg_rd_data[DATA_W-1];
            end
            // First fall after the last address bit must keep the MSB.
            if (w_sclk_fall && r_rw && r_bit_cnt > CMD_DONE) begin
              r_tx     <= r_tx << 1;
              spi_miso <= r_tx[DATA_W-2];
            end
            if (w_sclk_rise) begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              r_data_sh <= w_data_nxt;
              if (r_bit_cnt == FRAME_LAST) begin
                r_state  <= WAIT_CS;
                spi_miso <= 1'b0;
                if (!r_rw) begin
                  reg_wr_en   <= 1'b1;
                  reg_addr    <= r_addr_sh;
                  reg_wr_data <= w_data_nxt;
                end
              end
            end
          end
        end

        WAIT_CS: begin
          spi_miso <= 1'b0;
          if (w_cs_rise) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: vector table of frames plus
// abort, overrun and mid-frame reset sequences.
module tb_spi_reg_bridge;

  logic        clk;
  logic        rst;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wr_data;
  logic [15:0] reg_rd_data;
  logic        frame_err;

  logic [15:0] mem [128];

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  spi_reg_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .reg_wr_en   (reg_wr_en),
    .reg_rd_en   (reg_rd_en),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .reg_rd_data (reg_rd_data),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Host register file: registered read, data valid one clk after strobe.
  always @(posedge clk) begin
    if (reg_wr_en) mem[reg_addr] <= reg_wr_data;
    if (reg_rd_en) reg_rd_data <= mem[reg_addr];
  end

  always @(negedge clk) begin
    if (reg_wr_en) wr_cnt++;
    if (reg_rd_en) rd_cnt++;
    if (frame_err) err_cnt++;
    if (reg_wr_en && reg_rd_en) both_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(5);
  endtask

  task automatic cs_high(input int gap);
    tick(5);
    spi_cs_n = 1'b1;
    tick(gap);
  endtask

  // sclk = clk/10; MISO sampled at each rising sclk edge.
  task automatic shift_bits(input logic [31:0] bits, input int n,
                            output logic [31:0] miso);
    miso = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = bits[i];
      tick(5);
      spi_sclk = 1'b1;
      miso = {miso[30:0], spi_miso};
      tick(5);
      spi_sclk = 1'b0;
    end
  endtask

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [15:0] data;
    int          exp_wr;
    int          exp_rd;
    logic [15:0] exp_miso;
  } vec_t;

  vec_t vec [8];

  initial begin
    logic [31:0] mo;
    logic [31:0] fr;
    int w0, r0, e0;

    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    mem[5] = 16'hA5C3;
    reg_rd_data = '0;

    vec[0] = '{1'b0, 7'h12, 16'hBEEF, 1, 0, 16'h0000};
    vec[1] = '{1'b1, 7'h05, 16'h0000, 0, 1, 16'hA5C3};
    vec[2] = '{1'b0, 7'h33, 16'h1234, 1, 0, 16'h0000};
    vec[3] = '{1'b1, 7'h33, 16'h0000, 0, 1, 16'h1234};
    vec[4] = '{1'b0, 7'h00, 16'h0000, 1, 0, 16'h0000};
    vec[5] = '{1'b1, 7'h12, 16'h0000, 0, 1, 16'hBEEF};
    vec[6] = '{1'b0, 7'h7F, 16'h8001, 1, 0, 16'h0000};
    vec[7] = '{1'b1, 7'h7F, 16'h0000, 0, 1, 16'h8001};

    rst = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_miso", {31'd0, spi_miso}, 32'd0);
    chk("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
    chk("rst_rd_en", {31'd0, reg_rd_en}, 32'd0);
    chk("rst_addr", {25'd0, reg_addr}, 32'd0);
    chk("rst_wdata", {16'd0, reg_wr_data}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick(10);

    // Table: back-to-back frames with a 4-clk cs_n-high gap.
    for (int k = 0; k < 8; k++) begin
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
      fr = {8'd0, vec[k].rw, vec[k].addr, vec[k].data};
      cs_low();
      shift_bits(fr, 24, mo);
      cs_high(4);
      chk($sformatf("v%0d_wr", k), wr_cnt - w0, vec[k].exp_wr);
      chk($sformatf("v%0d_rd", k), rd_cnt - r0, vec[k].exp_rd);
      chk($sformatf("v%0d_err", k), err_cnt - e0, 0);
      chk($sformatf("v%0d_miso", k), {16'd0, mo[15:0]},
          {16'd0, vec[k].exp_miso});
      chk($sformatf("v%0d_addr", k), {25'd0, reg_addr},
          {25'd0, vec[k].addr});
      if (!vec[k].rw)
        chk($sformatf("v%0d_wdata", k), {16'd0, reg_wr_data},
            {16'd0, vec[k].data});
    end

    // Abort after 12 bits, then a normal write.
    w0 = wr_cnt; e0 = err_cnt;
    fr = {8'd0, 1'b0, 7'h20, 16'hCAFE};
    cs_low();
    shift_bits(fr >> 12, 12, mo);
    cs_high(10);
    chk("abort_wr", wr_cnt - w0, 0);
    chk("abort_err", err_cnt - e0, 1);
    w0 = wr_cnt; e0 = err_cnt;
    cs_low();
    shift_bits({8'd0, 1'b0, 7'h01, 16'h0001}, 24, mo);
    cs_high(4);
    chk("post_abort_wr", wr_cnt - w0, 1);
    chk("post_abort_addr", {25'd0, reg_addr}, 32'h01);
    chk("post_abort_wdata", {16'd0, reg_wr_data}, 32'h0001);
    chk("post_abort_err", err_cnt - e0, 0);

    // 30 pulses in one cs_n window: trailing 6 ignored.
    w0 = wr_cnt; e0 = err_cnt;
    cs_low();
    shift_bits({2'd0, 1'b0, 7'h7F, 16'hFFFF, 6'h3F}, 30, mo);
    cs_high(4);
    chk("long_wr", wr_cnt - w0, 1);
    chk("long_addr", {25'd0, reg_addr}, 32'h7F);
    chk("long_wdata", {16'd0, reg_wr_data}, 32'hFFFF);
    chk("long_err", err_cnt - e0, 0);

    // Reset at bit 20 of a write frame.
    w0 = wr_cnt; r0 = rd_cnt;
    fr = {8'd0, 1'b0, 7'h44, 16'h5555};
    cs_low();
    shift_bits(fr >> 4, 20, mo);
    rst = 1'b0;
    tick(1);
    chk("mid_rst_miso", {31'd0, spi_miso}, 32'd0);
    chk("mid_rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
    chk("mid_rst_rd_en", {31'd0, reg_rd_en}, 32'd0);
    chk("mid_rst_addr", {25'd0, reg_addr}, 32'd0);
    chk("mid_rst_wdata", {16'd0, reg_wr_data}, 32'd0);
    chk("mid_rst_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    shift_bits(fr, 4, mo);
    cs_high(6);
    chk("mid_rst_no_wr", wr_cnt - w0, 0);
    chk("mid_rst_no_rd", rd_cnt - r0, 0);
    w0 = wr_cnt;
    cs_low();
    shift_bits({8'd0, 1'b0, 7'h45, 16'h6789}, 24, mo);
    cs_high(4);
    chk("post_rst_wr", wr_cnt - w0, 1);
    chk("post_rst_addr", {25'd0, reg_addr}, 32'h45);
    chk("post_rst_wdata", {16'd0, reg_wr_data}, 32'h6789);

    chk("wr_rd_excl", both_cnt, 0);
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
